// File: rtl/load_arbiter_pkg.sv
// load_arb_pkg: shared FSM state type, lock cap and select-width helper for load_arbiter.
package load_arb_pkg;
  typedef enum logic {IDLE, ISSUE} state_e;
  localparam int LOCK_MAX = 4;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/load_arbiter_if.sv
// load_arbiter_if: requester/target bundle of load_arbiter; lock exists only with LOAD_ARB_LOCK_EN.
interface load_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int SELW  = load_arb_pkg::sel_w(N_REQ)
) ();
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    ack;
  logic                out_load;
  logic [DW-1:0]       out_data;
  logic [SELW-1:0]     out_sel;
  logic                out_ready;
  logic                busy;
`ifdef LOAD_ARB_LOCK_EN
  logic [N_REQ-1:0]    lock;
`endif
  modport slave (
    input  req, wdata, out_ready,
`ifdef LOAD_ARB_LOCK_EN
    input  lock,
`endif
    output ack, out_load, out_data, out_sel, busy
  );
  modport master (
    output req, wdata, out_ready,
`ifdef LOAD_ARB_LOCK_EN
    output lock,
`endif
    input  ack, out_load, out_data, out_sel, busy
  );
endinterface

// File: rtl/load_arbiter_ack_demux_tree.sv
// ack_demux_tree: 1-to-N_REQ one-hot demultiplexer built as a binary tree of 1:2 DMUX cells.
module ack_demux_tree #(
  parameter int N_REQ = 4,
  parameter int SELW  = 2
) (
  input  logic             in,
  input  logic [SELW-1:0]  sel,
  output logic [N_REQ-1:0] out
);
  localparam int P = 2 ** SELW;
  // Heap-ordered nodes: root 0, children 2n+1/2n+2; leaves P-1.. are outputs in index order.
  logic [2*P-2:0] t;
  assign t[0] = in;
  for (genvar l = 0; l < SELW; l++) begin : g_lvl
    for (genvar i = 0; i < 2 ** l; i++) begin : g_cell
      localparam int N = 2 ** l - 1 + i;
      assign t[2*N+1] = t[N] & ~sel[SELW-1-l];
      assign t[2*N+2] = t[N] &  sel[SELW-1-l];
    end
  end
  assign out = t[P-1 +: N_REQ];
endmodule

// File: rtl/load_arbiter.sv
// load_arbiter: round-robin arbiter sharing one target load port among N_REQ requesters.
// Optional LOAD_ARB_LOCK_EN adds per-requester lock with a capped run of repeated grants.
module load_arbiter
  import load_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int SELW  = sel_w(N_REQ)
) (
  input logic           clk,
  input logic           rst_n,
  load_arbiter_if.slave bus
);
  state_e          state_q, state_d;
  logic [SELW-1:0] last_q, last_d, sel_q, sel_d, win;
  logic [DW-1:0]   data_q, data_d;
  logic            done, hold;
  int              idx;
  assign done = (state_q == ISSUE) && bus.out_ready;
  // Descending scan so the closest requester after last_q is the final assignment.
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (bus.req[idx]) win = SELW'(idx);
    end
  end
`ifdef LOAD_ARB_LOCK_EN
  logic [2:0] cnt_q, cnt_d;
  assign hold  = done && bus.lock[sel_q] && bus.req[sel_q] && (cnt_q < 3'(LOCK_MAX - 1));
  assign cnt_d = done ? (hold ? cnt_q + 3'd1 : 3'd0) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign hold = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (state_q == IDLE && |bus.req) begin
      state_d = ISSUE;
      sel_d   = win;
      data_d  = bus.wdata[int'(win)*DW +: DW];
    end else if (done) begin
      state_d = IDLE;
      // A held lock restarts the search at the current owner so it wins again.
      last_d  = hold ? ((sel_q == '0) ? SELW'(N_REQ - 1) : sel_q - 1'b1) : sel_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SELW'(N_REQ - 1);
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  assign bus.out_load = (state_q == ISSUE);
  assign bus.busy     = (state_q == ISSUE);
  assign bus.out_sel  = sel_q;
  assign bus.out_data = data_q;
  ack_demux_tree #(.N_REQ(N_REQ), .SELW(SELW)) u_ack (
    .in (bus.out_load & bus.out_ready),
    .sel(sel_q),
    .out(bus.ack)
  );
endmodule
